// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART receive-side frame controller.
package uart_frame_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } frm_state_t;

  typedef struct packed {
    logic chk;
    logic len;
    logic tmo;
    logic ovf;
  } frm_err_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port, one async read port, no reset.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  // Payload byte capture
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser: SOF | LEN | payload | CHK with length/checksum/timeout checks and a held-frame buffer.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SOF         = SOF_DEFAULT,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000,
  localparam int unsigned LW = $clog2(MAX_LEN + 1),
  localparam int unsigned AW = $clog2(MAX_LEN),
  localparam int unsigned TW = $clog2(TIMEOUT_CYC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_ready,
  input  logic [7:0]    rx_data,
  output logic          frm_valid,
  output logic [LW-1:0] frm_len,
  input  logic          frm_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_tmo,
  output logic          err_ovf
);

  frm_state_t    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  frm_err_t      err_q, err_d;
  logic          valid_q, busy_q;
  logic [LW-1:0] frm_len_q;

  logic          wr_en;
  logic [7:0]    sum_nx;
  logic          in_frame;
  logic          tmo_exp;

  // Next-state, datapath and error decode
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    tmo_d    = '0;
    err_d    = '0;
    wr_en    = 1'b0;
    sum_nx   = sum_q + rx_data;
    in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
    // A byte in the expiry cycle wins over the timeout
    tmo_exp  = in_frame && !rx_ready && (tmo_q == TW'(TIMEOUT_CYC - 2));

    if (in_frame && !rx_ready) tmo_d = tmo_q + TW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (rx_ready && (rx_data == SOF)) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_ready) begin
          if ((rx_data == 8'd0) || (32'(rx_data) > MAX_LEN)) begin
            err_d.len = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = LW'(rx_data);
            idx_d   = '0;
            sum_d   = rx_data;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_ready) begin
          wr_en = 1'b1;
          idx_d = idx_q + LW'(1);
          sum_d = sum_nx;
          if ((idx_q + LW'(1)) == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_ready) begin
          if (sum_nx == 8'd0) begin
            state_d = S_HOLD;
          end else begin
            err_d.chk = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // Ack wins over a same-cycle byte; the byte is simply discarded
        if (frm_ack)       state_d   = S_IDLE;
        else if (rx_ready) err_d.ovf = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_exp) begin
      err_d.tmo = 1'b1;
      state_d   = S_IDLE;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      frm_len_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      valid_q   <= (state_d == S_HOLD);
      busy_q    <= (state_d == S_LEN) || (state_d == S_PAYLOAD) || (state_d == S_CHK);
      frm_len_q <= (state_d == S_HOLD) ? len_d : '0;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (AW'(idx_q)),
    .wr_data_i (rx_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign frm_valid = valid_q;
  assign frm_len   = frm_len_q;
  assign busy      = busy_q;
  assign err_chk   = err_q.chk;
  assign err_len   = err_q.len;
  assign err_tmo   = err_q.tmo;
  assign err_ovf   = err_q.ovf;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl (MAX_LEN=16, TIMEOUT_CYC=8).
module tb_uart_frame_ctrl;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TMO     = 8;
  localparam int unsigned LW      = 5;
  localparam int unsigned AW      = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          frm_ack = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          frm_valid, busy;
  logic [LW-1:0] frm_len;
  logic [7:0]    rd_data;
  logic          err_chk, err_len, err_tmo, err_ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int n_step = 0;

  // err field order: {chk, len, tmo, ovf}
  typedef struct {
    logic          rdy;
    logic [7:0]    d;
    logic          ack;
    logic          v;
    logic [LW-1:0] len;
    logic          bsy;
    logic [3:0]    err;
    logic          rd_en;
    logic [AW-1:0] ra;
    logic [7:0]    re;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  uart_frame_ctrl #(
    .SOF         (8'hA5),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .frm_valid (frm_valid),
    .frm_len   (frm_len),
    .frm_ack   (frm_ack),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .err_chk   (err_chk),
    .err_len   (err_len),
    .err_tmo   (err_tmo),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  function automatic vec_t T(input logic rdy, input logic [7:0] d, input logic ack,
                             input logic v, input int len, input logic bsy,
                             input logic [3:0] err);
    vec_t r;
    r.rdy = rdy; r.d = d; r.ack = ack;
    r.v = v; r.len = LW'(len); r.bsy = bsy; r.err = err;
    r.rd_en = 1'b0; r.ra = '0; r.re = 8'h00;
    return r;
  endfunction

  function automatic vec_t R(input vec_t t, input int ra, input logic [7:0] re);
    vec_t r;
    r = t;
    r.rd_en = 1'b1; r.ra = AW'(ra); r.re = re;
    return r;
  endfunction

  task automatic check_outs(input string nm, input logic v, input logic [LW-1:0] len,
                            input logic bsy, input logic [3:0] err);
    logic [10:0] got, want;
    got  = {frm_valid, frm_len, busy, err_chk, err_len, err_tmo, err_ovf};
    want = {v, len, bsy, err};
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s (step %0d): got v=%0b len=%0d busy=%0b err=%b, required v=%0b len=%0d busy=%0b err=%b",
               nm, n_step, frm_valid, frm_len, busy, {err_chk, err_len, err_tmo, err_ovf},
               v, len, bsy, err);
    end
  endtask

  // One clock cycle: drive, queue the expectation, pop it once the edge has produced outputs
  task automatic step(input vec_t t, input string nm);
    vec_t e;
    rx_ready = t.rdy;
    rx_data  = t.d;
    frm_ack  = t.ack;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    frm_ack  = 1'b0;
    n_step++;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty at step %0d", nm, n_step);
    end else begin
      e = exp_q.pop_front();
      check_outs(nm, e.v, e.len, e.bsy, e.err);
      if (e.rd_en) begin
        rd_addr = e.ra;
        #1;
        n_chk++;
        if (rd_data !== e.re) begin
          n_fail++;
          $display("FAIL %s rd[%0d]: got %h, required %h", nm, e.ra, rd_data, e.re);
        end
      end
    end
  endtask

  initial begin
    // Good frame A5 03 11 22 33 97, read back, ack
    tbl.push_back(T(1, 8'hA5, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h03, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h11, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h22, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h33, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h97, 0, 1, 3, 0, 4'b0000));
    tbl.push_back(R(T(0, 8'h00, 0, 1, 3, 0, 4'b0000), 0, 8'h11));
    tbl.push_back(R(T(0, 8'h00, 0, 1, 3, 0, 4'b0000), 1, 8'h22));
    tbl.push_back(R(T(0, 8'h00, 0, 1, 3, 0, 4'b0000), 2, 8'h33));
    tbl.push_back(T(0, 8'h00, 1, 0, 0, 0, 4'b0000));
    // Bad checksum 96
    tbl.push_back(T(1, 8'hA5, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h03, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h11, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h22, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h33, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h96, 0, 0, 0, 0, 4'b1000));
    tbl.push_back(T(0, 8'h00, 0, 0, 0, 0, 4'b0000));
    // Following good frame A5 01 42 BD
    tbl.push_back(T(1, 8'hA5, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h01, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h42, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(R(T(1, 8'hBD, 0, 1, 1, 0, 4'b0000), 0, 8'h42));
    tbl.push_back(T(0, 8'h00, 1, 0, 0, 0, 4'b0000));
    // Length errors: 0 and MAX_LEN+1
    tbl.push_back(T(1, 8'hA5, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h00, 0, 0, 0, 0, 4'b0100));
    tbl.push_back(T(1, 8'hA5, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h11, 0, 0, 0, 0, 4'b0100));
    tbl.push_back(T(0, 8'h00, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(T(1, 8'h55, 0, 0, 0, 0, 4'b0000));
    // SOF as payload data, stray ack mid-frame ignored
    tbl.push_back(T(1, 8'hA5, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'h02, 1, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'hA5, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(T(1, 8'hA5, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(R(T(1, 8'hB4, 0, 1, 2, 0, 4'b0000), 0, 8'hA5));
    // Overflow in HOLD, buffer unchanged, then ack+byte together
    tbl.push_back(R(T(1, 8'h55, 0, 1, 2, 0, 4'b0001), 1, 8'hA5));
    tbl.push_back(R(T(0, 8'h00, 0, 1, 2, 0, 4'b0000), 2, 8'h33));
    tbl.push_back(T(1, 8'h77, 1, 0, 0, 0, 4'b0000));
    tbl.push_back(T(0, 8'h00, 0, 0, 0, 0, 4'b0000));

    // Reset state
    #2;
    check_outs("reset_state", 0, '0, 0, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i], "table");

    // Timeout: A5 02 11 then silence, err_tmo at the 7th cycle after the last strobe
    step(T(1, 8'hA5, 0, 0, 0, 1, 4'b0000), "tmo_hdr");
    step(T(1, 8'h02, 0, 0, 0, 1, 4'b0000), "tmo_hdr");
    step(T(1, 8'h11, 0, 0, 0, 1, 4'b0000), "tmo_hdr");
    for (int k = 1; k < 7; k++) step(T(0, 8'h00, 0, 0, 0, 1, 4'b0000), "tmo_wait");
    step(T(0, 8'h00, 0, 0, 0, 0, 4'b0010), "tmo_fire");
    step(T(0, 8'h00, 0, 0, 0, 0, 4'b0000), "tmo_pulse_end");

    // Byte exactly in the expiry cycle wins
    step(T(1, 8'hA5, 0, 0, 0, 1, 4'b0000), "tmo_edge");
    step(T(1, 8'h02, 0, 0, 0, 1, 4'b0000), "tmo_edge");
    step(T(1, 8'h11, 0, 0, 0, 1, 4'b0000), "tmo_edge");
    for (int k = 1; k < 7; k++) step(T(0, 8'h00, 0, 0, 0, 1, 4'b0000), "tmo_edge_wait");
    step(T(1, 8'h22, 0, 0, 0, 1, 4'b0000), "tmo_edge_byte");
    step(R(T(1, 8'hCB, 0, 1, 2, 0, 4'b0000), 1, 8'h22), "tmo_edge_chk");
    step(T(0, 8'h00, 1, 0, 0, 0, 4'b0000), "tmo_edge_ack");

    // Async reset mid-payload
    step(T(1, 8'hA5, 0, 0, 0, 1, 4'b0000), "rst_frame");
    step(T(1, 8'h03, 0, 0, 0, 1, 4'b0000), "rst_frame");
    step(T(1, 8'h11, 0, 0, 0, 1, 4'b0000), "rst_frame");
    #2;
    rst = 1'b0;
    #1;
    check_outs("rst_async", 0, '0, 0, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(T(1, 8'h00, 0, 0, 0, 0, 4'b0000), "rst_junk");
    step(T(1, 8'hFF, 0, 0, 0, 0, 4'b0000), "rst_junk");
    step(T(0, 8'h00, 0, 0, 0, 0, 4'b0000), "rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Receive-side frame controller sequencing the UART byte receiver: consumes its one-cycle byte strobes, parses `SOF | LEN | payload | CHK` frames, validates length and checksum, supervises inter-byte timeout, and holds each good frame in a local buffer until the consumer acknowledges it. Sits between the UART receiver wrapper and the command decoder / display logic of the lab design.

## Interface
- `SOF`, 8'hA5: start-of-frame byte.
- `MAX_LEN`, 16: maximum payload bytes (≥1).
- `TIMEOUT_CYC`, 50000: clk cycles allowed between bytes inside a frame (≥2).
- `clk` in 1: system clock, single domain.
- `rst` in 1: asynchronous, active-low reset.
- `rx_ready` in 1: byte strobe from receiver, one cycle wide.
- `rx_data` in 8: received byte, valid when `rx_ready`=1.
- `frm_valid` out 1: a checked frame is held in the buffer.
- `frm_len` out LW=$clog2(MAX_LEN+1): payload length of held frame.
- `frm_ack` in 1: consumer releases held frame.
- `rd_addr` in $clog2(MAX_LEN): buffer read index.
- `rd_data` out 8: buffer[rd_addr], combinational read.
- `busy` out 1: parser is mid-frame (LEN/PAYLOAD/CHK).
- `err_chk`, `err_len`, `err_tmo`, `err_ovf` out 1 each: one-cycle error pulses.

## Operation
- States: IDLE, LEN, PAYLOAD, CHK, HOLD.
- IDLE: `rx_ready` with `rx_data`==SOF → LEN; other bytes silently ignored.
- LEN: byte 0 or >MAX_LEN → `err_len`, IDLE. Else latch len, clear index, sum:=byte → PAYLOAD.
- PAYLOAD: each byte written to buffer[index], index+1, sum+=byte (mod 256); after len-th byte → CHK.
- CHK: (sum+byte) mod 256 == 0 → HOLD; else `err_chk`, IDLE. The sum covers LEN, payload, and CHK.
- HOLD: `frm_valid`=1 and `frm_len` stable. Buffer is never written in HOLD. `frm_ack` → IDLE. A byte arriving without ack → dropped, `err_ovf`.
- HOLD with `frm_ack` and `rx_ready` in the same cycle: ack wins, go to IDLE, byte discarded, no `err_ovf`.
- `frm_ack` outside HOLD: ignored.
- Timeout: counter cleared on every `rx_ready` and on entering LEN. It counts in LEN/PAYLOAD/CHK. Reaching TIMEOUT_CYC-1 with no byte → `err_tmo`, IDLE, partial frame discarded. A byte in the expiry cycle wins (processed normally, no timeout).
- A SOF value inside LEN/PAYLOAD/CHK is treated as data (no resync).
- Buffer contents after an error are undefined. Only HOLD guarantees them.

## Timing
- Reset (rst=0, async): state IDLE, counters 0, all outputs 0, `rd_data` undefined (buffer not reset).
- All outputs except `rd_data` are registered.
- `frm_valid` rises the cycle after the CHK strobe. It falls the cycle after `frm_ack`.
- Error pulses are high exactly one cycle, the cycle after the causing strobe or the timeout cycle.
- `busy` is high while state ∈ {LEN, PAYLOAD, CHK}.
- Back-to-back strobes on consecutive cycles are accepted (no throughput limit).
- `rd_data` reflects `rd_addr` in the same cycle.
- `rst` asserted mid-frame aborts immediately. No error pulse after release.

## Structure
- Package `uart_frame_pkg`: state enum `frm_state_t`, default SOF constant, a `frm_err_t` struct bundling the four error bits.
- Sub-module `uart_frame_buf`: MAX_LEN×8 register file with one write port and one async read port, no reset.
- The controller holds the FSM, timeout counter, length/index/sum registers.

## Test plan
- Good frame A5 03 11 22 33 97 → `frm_valid`=1 one cycle after the 97 strobe, `frm_len`=3, rd 0/1/2 = 11/22/33. Ack → `frm_valid`=0 next cycle.
- Same frame with CHK 96 → `err_chk` one pulse, no `frm_valid`, `busy` low. A following good frame is accepted.
- A5 00 and A5 11 (MAX_LEN=16) → `err_len` pulse each, state IDLE.
- TIMEOUT_CYC=8: send A5 02 11, then idle → `err_tmo` 7 cycles after the last strobe. A byte sent at exactly cycle 7 instead → no error.
- In HOLD, send byte 55 → `err_ovf` pulse, buffer unchanged. Byte with simultaneous `frm_ack` → no `err_ovf`, `frm_valid` falls.
- Async `rst` low mid-payload → all outputs 0 immediately. After release, junk bytes 00 FF are ignored.
